// File: rtl/exhaustive_vector_sequencer.sv
// -----------------------------------------------------------------------------
// exhaustive_vector_sequencer
//
// Walks every 2^NUM_IN input pattern of a benchmark DUT in ascending order.
// Each pattern is held for SETTLE_CYC cycles. The DUT response is then sampled
// and offered to a logger as a {vector, response} record over valid/ready.
// Every accepted response is folded into a MISR signature, so a golden run and
// a suspect run can be compared by signature alone.
//
// Ports
//   CK         in   1        clock, all state on rising edge
//   reset      in   1        asynchronous, active-high reset
//   start      in   1        begin sweep (sampled only in IDLE)
//   abort      in   1        cancel sweep, back to IDLE on next edge
//   vec_out    out  NUM_IN   stimulus to DUT inputs
//   dut_out    in   NUM_OUT  DUT response
//   rec_valid  out  1        record available
//   rec_ready  in   1        logger accepts record
//   rec_vec    out  NUM_IN   vector of current record
//   rec_resp   out  NUM_OUT  sampled response of current record
//   busy       out  1        high in APPLY/EMIT
//   done       out  1        one-cycle pulse at sweep completion
//   signature  out  SIG_W    MISR over all accepted responses
// -----------------------------------------------------------------------------
module exhaustive_vector_sequencer #(
    parameter int                 NUM_IN     = 5,
    parameter int                 NUM_OUT    = 1,
    parameter int                 SETTLE_CYC = 1,
    parameter int                 SIG_W      = 16,
    parameter logic [SIG_W-1:0]   POLY       = SIG_W'(16'h1021)
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_IN-1:0]     vec_out,
    input  logic [NUM_OUT-1:0]    dut_out,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [NUM_IN-1:0]     rec_vec,
    output logic [NUM_OUT-1:0]    rec_resp,
    output logic                  busy,
    output logic                  done,
    output logic [SIG_W-1:0]      signature
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [NUM_IN-1:0]   vec_q,       vec_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [NUM_IN-1:0]   rec_vec_q,   rec_vec_d;
    logic [NUM_OUT-1:0]  rec_resp_q,  rec_resp_d;
    logic [SIG_W-1:0]    sig_q,       sig_d;
    logic                rec_valid_q, rec_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // One MISR step: shift left, fold the MSB back through POLY, inject the response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0]   sig,
                                                   input logic [NUM_OUT-1:0] resp);
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        rec_vec_d  = rec_vec_q;
        rec_resp_d = rec_resp_q;
        sig_d      = sig_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort because abort is not looked at here
                if (start) begin
                    state_d = ST_APPLY;
                    sig_d   = {SIG_W{1'b0}};
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    rec_resp_d = dut_out;
                    rec_vec_d  = vec_q;
                    state_d    = ST_EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EMIT: begin
                // abort beats the handshake: that record is treated as never accepted
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rec_ready) begin
                    sig_d = misr_step(sig_q, rec_resp_q);
                    if (vec_q == {NUM_IN{1'b1}}) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + NUM_IN'(1);
                        cnt_d   = CNT_LOAD;
                        state_d = ST_APPLY;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stimulus is parked at zero whenever the sequencer is idle.
        if (state_d == ST_IDLE) begin
            vec_d = {NUM_IN{1'b0}};
        end else begin
            vec_d = vec_d;
        end

        // Status flags are decoded from the next state so they change with it.
        rec_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d == ST_APPLY) || (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vec_q       <= {NUM_IN{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rec_vec_q   <= {NUM_IN{1'b0}};
            rec_resp_q  <= {NUM_OUT{1'b0}};
            sig_q       <= {SIG_W{1'b0}};
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            rec_vec_q   <= rec_vec_d;
            rec_resp_q  <= rec_resp_d;
            sig_q       <= sig_d;
            rec_valid_q <= rec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec_out   = vec_q;
    assign rec_valid = rec_valid_q;
    assign rec_vec   = rec_vec_q;
    assign rec_resp  = rec_resp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for exhaustive_vector_sequencer (default params).
// The DUT under test is modelled by a small mux: response = vec[4], 0 or 1.
// -----------------------------------------------------------------------------
module tb_exhaustive_vector_sequencer;

    logic        CK = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  vec_out;
    logic [0:0]  dut_out;
    logic        rec_valid;
    logic        rec_ready;
    logic [4:0]  rec_vec;
    logic [0:0]  rec_resp;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    logic [1:0]  mode;
    int          n_checks = 0;
    int          n_pass   = 0;

    exhaustive_vector_sequencer dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .vec_out   (vec_out),
        .dut_out   (dut_out),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_vec   (rec_vec),
        .rec_resp  (rec_resp),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    always #5 CK = ~CK;

    // Benchmark DUT stand-in: mode 0 -> vec[4], mode 1 -> 0, mode 2 -> 1.
    always_comb begin
        if (mode == 2'd0)      dut_out = vec_out[4];
        else if (mode == 2'd2) dut_out = 1'b1;
        else                   dut_out = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_resp(input int v);
        logic [4:0] vv;
        vv = v[4:0];
        if (mode == 2'd0)      return vv[4];
        else if (mode == 2'd2) return 1'b1;
        else                   return 1'b0;
    endfunction

    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic r);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ r;
        return n;
    endfunction

    logic [15:0] last_model;

    // Runs one sweep; optional stall, abort (in APPLY or EMIT) and stray start pulse.
    task automatic run_sweep(input int stall_at, input int abort_at, input bit abort_emit,
                             input int restart_at);
        int          exp_vec    = 0;
        int          n_done     = 0;
        int          done_cyc   = -1;
        int          stall_left = 0;
        int          stall_seen = 0;
        bit          stalled    = 1'b0;
        bit          fin        = 1'b0;
        logic [15:0] model      = 16'h0000;
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        check("sig_clear", 32'(signature), 32'h0);
        check("first_vec", 32'(vec_out), 32'h0);
        check("first_busy", 32'(busy), 32'h1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            rec_ready = 1'b1;
            start     = 1'b0;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_in_done", 32'(busy), 32'h0);
            end else if (done_cyc >= 0) begin
                fin = 1'b1;
            end
            if (!fin) begin
                if (stall_at >= 0 && rec_valid && rec_vec == stall_at[4:0]) begin
                    stall_seen++;
                    check("stall_resp", 32'(rec_resp), 32'(exp_resp(stall_at)));
                    if (!stalled) begin
                        stalled    = 1'b1;
                        stall_left = 5;
                    end
                end
                if (stall_left > 0) begin
                    rec_ready = 1'b0;
                    stall_left--;
                end
                if (restart_at >= 0 && busy && !rec_valid && vec_out == restart_at[4:0])
                    start = 1'b1;
                if (abort_at >= 0 && busy && (rec_valid == abort_emit) &&
                    vec_out == abort_at[4:0]) begin
                    abort = 1'b1;
                    @(negedge CK);
                    abort = 1'b0;
                    check("abort_busy", 32'(busy), 32'h0);
                    check("abort_vec", 32'(vec_out), 32'h0);
                    check("abort_valid", 32'(rec_valid), 32'h0);
                    check("abort_done", 32'(done), 32'h0);
                    check("abort_sig", 32'(signature), 32'(model));
                    return;
                end
                if (rec_valid && rec_ready) begin
                    check("rec_vec", 32'(rec_vec), 32'(exp_vec));
                    check("rec_resp", 32'(rec_resp), 32'(exp_resp(exp_vec)));
                    model = misr_model(model, exp_resp(exp_vec));
                    exp_vec++;
                end
                @(negedge CK);
            end
        end
        check("n_records", 32'(exp_vec), 32'd32);
        check("n_done", 32'(n_done), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(64 + (stalled ? 5 : 0)));
        if (stall_at >= 0) check("stall_cycles", 32'(stall_seen), 32'd6);
        check("done_single", 32'(done), 32'h0);
        check("idle_vec", 32'(vec_out), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("signature", 32'(signature), 32'(model));
        repeat (3) @(negedge CK);
        check("sig_hold", 32'(signature), 32'(model));
        last_model = model;
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        rec_ready = 1'b1;
        mode      = 2'd0;
        repeat (2) @(negedge CK);
        check("rst_vec", 32'(vec_out), 32'h0);
        check("rst_valid", 32'(rec_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_sig", 32'(signature), 32'h0);
        check("rst_rec", 32'({rec_vec, rec_resp}), 32'h0);
        reset = 1'b0;
        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        check("idle_abort", 32'(busy), 32'h0);

        run_sweep(-1, -1, 1'b0, -1);     // plain sweep, resp = vec[4]
        run_sweep(7, -1, 1'b0, -1);      // backpressure on record 7
        run_sweep(-1, 10, 1'b0, -1);     // abort in APPLY of vec 10
        run_sweep(-1, -1, 1'b0, -1);     // restart begins at vec 0
        run_sweep(-1, 20, 1'b1, -1);     // abort beats handshake in EMIT of vec 20
        run_sweep(-1, -1, 1'b0, 3);      // stray start while busy

        mode = 2'd1;
        run_sweep(-1, -1, 1'b0, -1);
        check("sig_all0", 32'(signature), 32'h0);
        mode = 2'd2;
        run_sweep(-1, -1, 1'b0, -1);
        run_sweep(-1, -1, 1'b0, -1);

        // start and abort together in IDLE: start wins
        @(negedge CK); start = 1'b1; abort = 1'b1;
        @(negedge CK); start = 1'b0; abort = 1'b0;
        check("start_vs_abort", 32'(busy), 32'h1);

        // asynchronous reset mid-EMIT of vec 20 (signature nonzero by then)
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (rec_valid && rec_vec == 5'd20) found = 1'b1;
            else @(negedge CK);
        end
        check("reached_emit20", 32'(found), 32'h1);
        check("sig_nonzero", 32'(signature != 16'h0), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("arst_valid", 32'(rec_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_vec", 32'(vec_out), 32'h0);
        check("arst_sig", 32'(signature), 32'h0);
        @(negedge CK);
        reset = 1'b0;

        mode = 2'd0;
        run_sweep(-1, -1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
